// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter: o_tick marks the last cycle of every ClksPerBit-cycle bit period.
module uart_tx_baud #(
   parameter int ClksPerBit = 16
) (
   input  logic i_clk,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CntW = $clog2(ClksPerBit);

   logic [CntW-1:0] cnt;

   assign o_tick = (cnt == CntW'(ClksPerBit - 1));

   always_ff @(posedge i_clk) begin
      if (i_clear || o_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CntW'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first,
// valid/ready byte input, frame starts gated by a synchronised CTS.
module uart_tx
   import uart_pkg::*;
#(
   parameter int ClksPerBit = 16,
   parameter int StopBits   = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic       i_cts,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   tx_state_t state, state_next;

   logic [UART_DATA_BITS-1:0] shift;
   logic [2:0]                bit_idx;
   logic                      stop_idx;
   logic                      cts_meta, cts_sync;
   logic                      tick, take, last_stop, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                      parity_bit;
`endif

   assign take      = o_ready && i_valid;
   assign last_stop = (stop_idx == 1'(StopBits - 1));

   uart_tx_baud #(
      .ClksPerBit(ClksPerBit)
   ) u_baud (
      .i_clk  (i_clk),
      .i_clear(i_rst || (state == IDLE)),
      .o_tick (tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cts_meta <= 1'b0;
         cts_sync <= 1'b0;
      end else begin
         cts_meta <= i_cts;
         cts_sync <= cts_meta;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (take) state_next = START;
         START: if (tick) state_next = DATA;
         DATA: begin
            if (tick && (bit_idx == 3'(UART_DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_next = STOP;
`endif
         STOP:  if (tick && last_stop) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (take) begin
         shift    <= i_data;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= ^i_data;
`endif
      end else if ((state == DATA) && tick) begin
         shift   <= shift >> 1;
         bit_idx <= bit_idx + 3'd1;
      end else if ((state == STOP) && tick) begin
         stop_idx <= ~stop_idx;
      end
   end

   // o_tx is registered, so the line level is derived from the state being entered
   // and the shift register as it will look after this edge.
   always_comb begin
      o_ready = (state == IDLE) && cts_sync;
      o_busy  = (state != IDLE);
      o_done  = (state == STOP) && tick && last_stop;
      tx_d    = 1'b1;
      case (state_next)
         START:  tx_d = 1'b0;
         DATA:   tx_d = ((state == DATA) && tick) ? shift[1] : shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_d = parity_bit;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_tx <= 1'b1;
      end else begin
         o_tx <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (16 clk/bit 1 stop, 4 clk/bit 2 stops).
module tb_uart_tx;

   localparam int CA  = 16;
   localparam int SA  = 1;
   localparam int CB  = 4;
   localparam int SB  = 2;
   localparam int BIG = 1 << 30;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid, a_cts, b_cts;
   logic       a_ready, b_ready, a_tx, b_tx, a_busy, b_busy, a_done, b_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx #(.ClksPerBit(CA), .StopBits(SA)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
      .i_cts(a_cts), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done)
   );

   uart_tx #(.ClksPerBit(CB), .StopBits(SB)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
      .i_cts(b_cts), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line level of frame bit idx: start, D0..D7, [even parity], stop bits.
   function automatic int ref_bit(input logic [7:0] d, input int idx);
      int v    = int'(d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += (v / (1 << i)) % 2;
      if (idx == 0) return 0;
      if (idx <= 8) return (v / (1 << (idx - 1))) % 2;
      if (PAR == 1 && idx == 9) return ones % 2;
      return 1;
   endfunction

   // Offer byte d, expect handshake after exp_wait edges, then check every frame cycle.
   task automatic send(input int sel, input logic [7:0] d, input bit hold,
                       input int exp_wait, input int stop_at);
      int clks   = (sel != 0) ? CB : CA;
      int stops  = (sel != 0) ? SB : SA;
      int last   = (9 + PAR + stops) * clks;
      int waited = 0;
      if (sel != 0) begin b_data = d; b_valid = 1'b1; end
      else          begin a_data = d; a_valid = 1'b1; end
      while (!((sel != 0) ? b_ready : a_ready) && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("hs_wait", 32'(waited), 32'(exp_wait));
      if (waited >= 200) begin
         a_valid = 1'b0;
         b_valid = 1'b0;
         return;
      end
      for (int n = 1; n <= last && n <= stop_at; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            if (sel != 0) begin b_data = ~d; if (!hold) b_valid = 1'b0; end
            else          begin a_data = ~d; if (!hold) a_valid = 1'b0; end
         end
         chk("tx",   32'((sel != 0) ? b_tx   : a_tx),   32'(ref_bit(d, (n - 1) / clks)));
         chk("done", 32'((sel != 0) ? b_done : a_done), 32'(n == last));
         chk("busy", 32'((sel != 0) ? b_busy : a_busy), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      a_valid = 1'b0; a_data = '0; a_cts = 1'b1;
      b_valid = 1'b0; b_data = '0; b_cts = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx",    32'(a_tx),    32'd1);
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_busy",  32'(a_busy),  32'd0);
      chk("rst_done",  32'(a_done),  32'd0);
      chk("rst_btx",   32'(b_tx),    32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_r1", 32'(a_ready), 32'd0);
      @(posedge clk); #1;
      chk("ready_r2", 32'(a_ready), 32'd1);

      send(0, 8'h55, 1'b0, 0, BIG);
      send(0, 8'hA5, 1'b0, 1, BIG);
      send(0, 8'h07, 1'b0, 1, BIG);
      for (int i = 0; i < 6; i++) send(0, 8'($urandom_range(0, 255)), 1'b0, 1, BIG);

      // CTS low blocks the handshake; raising it allows one two cycles later
      a_cts = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      a_data  = 8'h3C;
      a_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("cts_ready", 32'(a_ready), 32'd0);
         chk("cts_tx",    32'(a_tx),    32'd1);
      end
      a_cts = 1'b1;
      send(0, 8'h3C, 1'b0, 2, BIG);

      // back-to-back with i_valid held: one mark cycle between frames
      send(0, 8'h00, 1'b1, 1, BIG);
      send(0, 8'hFF, 1'b1, 1, BIG);
      a_valid = 1'b0;

      // reset in the middle of the data bits
      send(0, 8'h81, 1'b0, 1, 3 * CA + 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_tx",   32'(a_tx),   32'd1);
      chk("mrst_busy", 32'(a_busy), 32'd0);
      chk("mrst_done", 32'(a_done), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("mrst_done2", 32'(a_done), 32'd0);
         chk("mrst_busy2", 32'(a_busy), 32'd0);
      end
      send(0, 8'h42, 1'b0, 0, BIG);

      // two stop bits, four clocks per bit
      send(1, 8'hF0, 1'b0, 0, BIG);
      send(1, 8'($urandom_range(0, 255)), 1'b0, 1, BIG);

      @(posedge clk); #1;
      chk("end_busy",  32'(a_busy),  32'd0);
      chk("end_tx",    32'(a_tx),    32'd1);
      chk("end_ready", 32'(a_ready), 32'd1);
      chk("end_bbusy", 32'(b_busy),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
